flash_cmd_sequencer: RTL and testbench
======================================

Name: flash_cmd_sequencer

Overview:
- Command-level controller for the QSPI/SPI NOR flash port.
- Accepts one host operation at a time and expands it into the flash byte sequence: WREN where needed, opcode, 24-bit address, data, then status polling until the erase/program finishes.
- Drives chip-select and a byte-wide SPI shifter (shifter = separate block; owns sclk/DI/DO).
- Sits between the host/bus side and that shifter.

Parameters:
- CS_GAP, 4: minimum clk cycles cs_n stays high between two flash commands.
- MAX_POLLS, 65535: RDSR reads allowed before a busy-wait times out.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. Reset is asynchronous and active-high.
- req_valid  in  1  host request valid.
- req_ready  out  1  sequencer idle; request accepted when req_valid & req_ready.
- req_op  in  3  0=READ(03h), 1=PAGE_PROG(02h), 2=SECTOR_ERASE(20h), 3=BLK_ERASE32(52h), 4=BLK_ERASE64(D8h), 5=READ_STATUS(05h); 6,7 illegal.
- req_addr  in  24  flash byte address.
- req_len  in  9  data byte count for READ/PAGE_PROG; 0 means 256.
- wr_valid  in  1  program-data byte available.
- wr_ready  out  1  program-data byte consumed this cycle.
- wr_data  in  8  program-data byte.
- rd_valid  out  1  one-cycle pulse: rd_data valid (no backpressure).
- rd_data  out  8  read/status byte.
- done  out  1  one-cycle pulse: operation complete.
- err  out  1  valid with done: 1 = illegal op or poll timeout.
- cs_n  out  1  flash chip select, active low.
- sh_start  out  1  one-cycle pulse: shift sh_tx_byte out/in.
- sh_tx_byte  out  8  byte to transmit; held stable until sh_done.
- sh_busy  in  1  shifter busy.
- sh_done  in  1  one-cycle pulse: byte exchange complete.
- sh_rx_byte  in  8  received byte, valid with sh_done.

Behaviour:
- All outputs registered.
- Reset values: req_ready=0, cs_n=1, sh_start=0, sh_tx_byte=00h, wr_ready=0, rd_valid=0, rd_data=00h, done=0, err=0. req_ready rises on the first clk after rst deasserts.
- Reset mid-operation: cs_n=1 immediately (async); all counters cleared; the in-flight operation is discarded with no done pulse.
- On accept: latch op, addr, len (0 maps to 256); req_ready=0 next cycle.
- Illegal op: no flash traffic; done=1, err=1 two cycles after accept; then back to IDLE.
- States: IDLE, WREN, GAP1, CMD, ADDR, DATA, GAP2, POLL, FINISH.
- Byte issue rule (every state): sh_start pulses only when sh_busy=0. cs_n falls in the same cycle as the first sh_start of a command. The state advances on sh_done.
- WREN: used by ops 1-4. cs_n low, send 06h, cs_n high after sh_done, then GAP1.
- GAP1 and GAP2: cs_n high for exactly CS_GAP cycles.
- CMD: send the opcode. Op 5 goes straight to DATA with 1 dummy byte (00h) and returns 1 rd byte.
- ADDR: send addr[23:16], then addr[15:8], then addr[7:0].
- DATA, READ: send 00h len times. Each sh_done gives rd_valid=1 and rd_data=sh_rx_byte for 1 cycle.
- DATA, PAGE_PROG: a byte is needed only when wr_valid=1; wr_ready pulses the cycle it is latched into sh_tx_byte. If wr_valid=0, wait with cs_n held low (bus stalls, no timeout).
- Erase ops: skip DATA.
- End of command: cs_n high after the last sh_done. READ/op 5 then go to FINISH. Ops 1-4 go to GAP2, then POLL.
- POLL: cs_n low, send 05h then 00h, cs_n high, then CS_GAP gap.
  - If received bit0 (WIP)=0: FINISH.
  - Otherwise repeat, counting polls.
  - Poll count reaching MAX_POLLS with WIP still 1: FINISH with err=1.
  - Poll results are not forwarded on rd_valid.
- FINISH: done=1 for 1 cycle (err as set); next cycle IDLE with req_ready=1.
- Address is not incremented and page wrap is not checked; wrap within a 256-byte page is the flash's behaviour.
- sh_done while no byte is outstanding: ignored.

Test Plan:
- READ addr=012345h len=4, DO returns A0,A1,A2,A3 -> shifter bytes 03,01,23,45,00x4; four rd_valid pulses with A0..A3; one cs_n low window; done=1, err=0.
- PAGE_PROG addr=000100h len=2, data 5A,C3, status returns 03h twice then 00h:
  - Expect 06 (own cs window), then CS_GAP=4 high cycles, then 02,00,01,00,5A,C3.
  - Then 3 poll windows (05,00 each); done after the third; err=0.
- PAGE_PROG with wr_valid held low 20 cycles before the second byte -> cs_n stays low throughout; no sh_start during the stall; second byte sent after wr_valid rises.
- SECTOR_ERASE with MAX_POLLS=3, status always 01h -> exactly 3 polls; done=1, err=1; cs_n=1 afterwards.
- req_op=7 -> no sh_start, cs_n stays 1; done=1, err=1; req_ready back to 1.
- Assert rst during the ADDR phase of READ -> cs_n=1 same cycle; no done pulse; after release req_ready=1 and a new READ completes normally.

Source files
------------

// File: rtl/flash_cmd_sequencer.sv
// flash_cmd_sequencer: expands host flash operations into WREN/opcode/address/data/status-poll byte sequences for a byte-wide SPI shifter.
module flash_cmd_sequencer #(
  parameter int CS_GAP = 4,
  parameter int MAX_POLLS = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [23:0] req_addr,
  input  logic [8:0]  req_len,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [7:0]  wr_data,
  output logic        rd_valid,
  output logic [7:0]  rd_data,
  output logic        done,
  output logic        err,
  output logic        cs_n,
  output logic        sh_start,
  output logic [7:0]  sh_tx_byte,
  input  logic        sh_busy,
  input  logic        sh_done,
  input  logic [7:0]  sh_rx_byte
);
  typedef enum logic [3:0] {IDLE, WREN, GAP1, CMD, ADDR, DATA, GAP2, POLL, FINISH} state_t;
  state_t state;
  logic [2:0] op;
  logic [23:0] addr;
  logic [8:0] len, cnt;
  logic [1:0] idx;
  logic [15:0] gap;
  logic [31:0] polls;
  logic pend, fail, last;
  logic [7:0] tx_byte, opcode;
  logic tx_avail, issue, fin, is_read, is_prog, is_erase;
  always_comb begin
    opcode = op == 3'd0 ? 8'h03 : op == 3'd1 ? 8'h02 : op == 3'd2 ? 8'h20 :
             op == 3'd3 ? 8'h52 : op == 3'd4 ? 8'hD8 : 8'h05;
    is_read = op == 3'd0 || op == 3'd5;
    is_prog = op == 3'd1;
    is_erase = op >= 3'd2 && op <= 3'd4;
    tx_avail = 1'b0;
    tx_byte = 8'h00;
    case (state)
      WREN: begin
        tx_avail = 1'b1;
        tx_byte = 8'h06;
      end
      CMD: begin
        tx_avail = 1'b1;
        tx_byte = opcode;
      end
      ADDR: begin
        tx_avail = 1'b1;
        tx_byte = idx == 2'd0 ? addr[23:16] : idx == 2'd1 ? addr[15:8] : addr[7:0];
      end
      DATA: begin
        tx_avail = is_prog ? wr_valid : 1'b1;
        tx_byte = is_prog ? wr_data : 8'h00;
      end
      POLL: begin
        tx_avail = 1'b1;
        tx_byte = idx == 2'd0 ? 8'h05 : 8'h00;
      end
      default: ;
    endcase
    issue = tx_avail && !pend && !sh_busy;
    fin = pend && sh_done;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      req_ready <= 1'b0;
      cs_n <= 1'b1;
      sh_start <= 1'b0;
      sh_tx_byte <= 8'h00;
      wr_ready <= 1'b0;
      rd_valid <= 1'b0;
      rd_data <= 8'h00;
      done <= 1'b0;
      err <= 1'b0;
      op <= 3'd0;
      addr <= 24'd0;
      len <= 9'd0;
      cnt <= 9'd0;
      idx <= 2'd0;
      gap <= 16'd0;
      polls <= 32'd0;
      pend <= 1'b0;
      fail <= 1'b0;
      last <= 1'b0;
    end else begin
      sh_start <= 1'b0;
      wr_ready <= 1'b0;
      rd_valid <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      // cs_n falls together with the first byte of every command window
      if (issue) begin
        sh_start <= 1'b1;
        sh_tx_byte <= tx_byte;
        cs_n <= 1'b0;
        pend <= 1'b1;
        wr_ready <= state == DATA && is_prog;
      end
      if (fin) pend <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            op <= req_op;
            addr <= req_addr;
            len <= req_len == 9'd0 ? 9'd256 : req_len;
            cnt <= 9'd0;
            idx <= 2'd0;
            polls <= 32'd0;
            last <= 1'b0;
            fail <= req_op > 3'd5;
            state <= req_op > 3'd5 ? FINISH : (req_op == 3'd0 || req_op == 3'd5) ? CMD : WREN;
          end
        end
        WREN: if (fin) begin
          cs_n <= 1'b1;
          gap <= 16'(CS_GAP - 1);
          state <= GAP1;
        end
        GAP1: if (gap <= 16'd1) state <= CMD; else gap <= gap - 16'd1;
        CMD: if (fin) begin
          if (op == 3'd5) begin
            len <= 9'd1;
            state <= DATA;
          end else begin
            idx <= 2'd0;
            state <= ADDR;
          end
        end
        ADDR: if (fin) begin
          if (idx != 2'd2) idx <= idx + 2'd1;
          else if (is_erase) begin
            cs_n <= 1'b1;
            gap <= 16'(CS_GAP - 1);
            state <= GAP2;
          end else state <= DATA;
        end
        DATA: if (fin) begin
          if (is_read) begin
            rd_valid <= 1'b1;
            rd_data <= sh_rx_byte;
          end
          if (cnt != len - 9'd1) cnt <= cnt + 9'd1;
          else begin
            cs_n <= 1'b1;
            gap <= 16'(CS_GAP - 1);
            state <= is_prog ? GAP2 : FINISH;
          end
        end
        GAP2: if (gap <= 16'd1) begin
          idx <= 2'd0;
          state <= last ? FINISH : POLL;
        end else gap <= gap - 16'd1;
        // WIP is judged on the status byte; the decision is applied after the gap
        POLL: if (fin) begin
          if (idx == 2'd0) idx <= 2'd1;
          else begin
            cs_n <= 1'b1;
            gap <= 16'(CS_GAP - 1);
            state <= GAP2;
            polls <= polls + 32'd1;
            if (!sh_rx_byte[0]) last <= 1'b1;
            else if (polls == 32'(MAX_POLLS - 1)) begin
              last <= 1'b1;
              fail <= 1'b1;
            end
          end
        end
        FINISH: begin
          done <= 1'b1;
          err <= fail;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// tb_flash_cmd_sequencer: randomized scoreboard bench with a shifter/flash responder and a writer for program data.
module tb_flash_cmd_sequencer;
  localparam int CS_GAP = 4;
  localparam int MAX_POLLS = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0, req_ready;
  logic [2:0] req_op = 3'd0;
  logic [23:0] req_addr = 24'd0;
  logic [8:0] req_len = 9'd0;
  logic wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic rd_valid, done, err, cs_n, sh_start, sh_busy, sh_done;
  logic [7:0] rd_data, sh_tx_byte, sh_rx_byte;
  int total = 0, bad = 0;
  int exp_tx[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_rd[$];
  logic [7:0] wr_q[$];
  int exp_err[$];
  int done_cnt = 0, start_cnt = 0, hi_cnt = 1000;
  int stall_at = -1, stall_len = 0, consumed = 0;
  logic prev_cs = 1'b1, busy_at_edge = 1'b0;

  always #5 clk = ~clk;

  flash_cmd_sequencer #(.CS_GAP(CS_GAP), .MAX_POLLS(MAX_POLLS)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_len(req_len), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .err(err),
    .cs_n(cs_n), .sh_start(sh_start), .sh_tx_byte(sh_tx_byte), .sh_busy(sh_busy),
    .sh_done(sh_done), .sh_rx_byte(sh_rx_byte)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int opc(input int op);
    case (op)
      0: return 'h03;
      1: return 'h02;
      2: return 'h20;
      3: return 'h52;
      4: return 'hD8;
      default: return 'h05;
    endcase
  endfunction

  initial forever begin
    @(posedge clk);
    busy_at_edge = sh_busy;
  end

  // shifter + flash responder: answers each byte from rx_q, random busy time, occasional stray sh_done
  initial begin
    int busy_left;
    logic [7:0] rx;
    logic act;
    sh_busy = 1'b0; sh_done = 1'b0; sh_rx_byte = 8'h00; act = 1'b0; busy_left = 0; rx = 8'h00;
    forever begin
      @(negedge clk);
      sh_done = 1'b0;
      if (rst) begin
        act = 1'b0;
        sh_busy = 1'b0;
      end else if (act) begin
        if (busy_left == 0) begin
          sh_done = 1'b1; sh_rx_byte = rx; sh_busy = 1'b0; act = 1'b0;
        end else busy_left--;
      end else if (sh_start) begin
        act = 1'b1; sh_busy = 1'b1; busy_left = $urandom_range(0, 2);
        rx = rx_q.size() > 0 ? rx_q.pop_front() : 8'h00;
      end else if ($urandom_range(0, 7) == 0) begin
        sh_done = 1'b1; sh_rx_byte = 8'($urandom);
      end
    end
  end

  // program-data source with random and directed stalls
  initial begin
    int age;
    wr_valid = 1'b0; wr_data = 8'h00; age = 0;
    forever begin
      @(negedge clk);
      if (rst) wr_valid = 1'b0;
      else begin
        if (wr_ready) begin
          check("wr_ready_expected", 32'(wr_q.size() > 0), 1);
          if (wr_q.size() > 0) void'(wr_q.pop_front());
          consumed++;
        end
        if (stall_at == consumed && stall_len > 0) begin
          if (age > 0) begin
            check("stall_no_start", 32'(sh_start), 0);
            check("stall_cs_low", 32'(cs_n), 0);
          end
          age++; stall_len--; wr_valid = 1'b0;
        end else begin
          age = 0;
          wr_valid = wr_q.size() > 0 && $urandom_range(0, 3) != 0;
          wr_data = wr_q.size() > 0 ? wr_q[0] : 8'h00;
        end
      end
    end
  end

  // monitor: pops the scoreboard whenever the DUT presents a byte, window end, read byte or done
  initial forever begin
    @(negedge clk);
    if (rst) begin
      prev_cs = 1'b1;
      hi_cnt = 1000;
    end else begin
      if (sh_start) begin
        start_cnt++;
        check("start_cs_low", 32'(cs_n), 0);
        check("start_not_busy", 32'(busy_at_edge), 0);
        check("tx_byte", 32'(sh_tx_byte), exp_tx.size() > 0 ? exp_tx.pop_front() : 32'hFFFF_FFFF);
      end
      if (cs_n && !prev_cs) check("cs_window_end", 32'hFFFF_FFFF, exp_tx.size() > 0 ? exp_tx.pop_front() : 0);
      if (!cs_n && prev_cs) check("cs_gap", 32'(hi_cnt >= CS_GAP), 1);
      hi_cnt = cs_n ? hi_cnt + 1 : 0;
      if (rd_valid) check("rd_data", 32'(rd_data), exp_rd.size() > 0 ? 32'(exp_rd.pop_front()) : 32'h100);
      if (done) begin
        done_cnt++;
        check("done_err", 32'(err), exp_err.size() > 0 ? exp_err.pop_front() : 32'hDEAD);
      end
      prev_cs = cs_n;
    end
  end

  task automatic start_op(input int op, input logic [23:0] a, input int len, input int b);
    int n, np, t;
    logic [7:0] d;
    n = len == 0 ? 256 : len;
    consumed = 0;
    if (op > 5) exp_err.push_back(1);
    else begin
      if (op >= 1 && op <= 4) begin
        exp_tx.push_back('h06); exp_tx.push_back(-1); rx_q.push_back(8'($urandom));
      end
      exp_tx.push_back(opc(op)); rx_q.push_back(8'($urandom));
      if (op != 5) for (int i = 0; i < 3; i++) begin
        exp_tx.push_back(int'(a[23 - 8 * i -: 8])); rx_q.push_back(8'($urandom));
      end
      if (op == 0 || op == 5) for (int i = 0; i < (op == 5 ? 1 : n); i++) begin
        d = 8'($urandom); exp_tx.push_back(0); rx_q.push_back(d); exp_rd.push_back(d);
      end
      if (op == 1) for (int i = 0; i < n; i++) begin
        d = 8'($urandom); wr_q.push_back(d); exp_tx.push_back(int'(d)); rx_q.push_back(8'($urandom));
      end
      exp_tx.push_back(-1);
      if (op >= 1 && op <= 4) begin
        np = b >= MAX_POLLS ? MAX_POLLS : b + 1;
        for (int i = 0; i < np; i++) begin
          exp_tx.push_back('h05); exp_tx.push_back(0); exp_tx.push_back(-1);
          rx_q.push_back(8'($urandom));
          rx_q.push_back(i < b ? (8'($urandom) | 8'h01) : (8'($urandom) & 8'hFE));
        end
      end
      exp_err.push_back(int'(op >= 1 && op <= 4 && b >= MAX_POLLS));
    end
    t = 0;
    while (!req_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("req_ready_wait", 32'(t < 2000), 1);
    req_valid = 1'b1; req_op = 3'(op); req_addr = a; req_len = 9'(len);
    @(negedge clk);
    req_valid = 1'b0;
    check("ready_drop", 32'(req_ready), 0);
    if (op > 5) begin
      check("illegal_no_done_yet", 32'(done), 0);
      @(negedge clk);
      check("illegal_done", 32'(done), 1);
      check("illegal_cs", 32'(cs_n), 1);
    end
  endtask

  task automatic run_op(input int op, input logic [23:0] a, input int len, input int b);
    int start, t;
    start = done_cnt;
    start_op(op, a, len, b);
    t = 0;
    while (done_cnt == start && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", 32'(done_cnt > start), 1);
    repeat (2) @(negedge clk);
    check("cs_idle", 32'(cs_n), 1);
    check("tx_left", 32'(exp_tx.size()), 0);
    check("rd_left", 32'(exp_rd.size()), 0);
    check("err_left", 32'(exp_err.size()), 0);
    check("wr_left", 32'(wr_q.size()), 0);
  endtask

  initial begin
    int t, s0, op, len;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_cs_n", 32'(cs_n), 1);
    check("rst_sh_start", 32'(sh_start), 0);
    check("rst_tx_byte", 32'(sh_tx_byte), 0);
    check("rst_wr_ready", 32'(wr_ready), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    check("ready_before_clk", 32'(req_ready), 0);
    @(negedge clk);
    check("ready_after_clk", 32'(req_ready), 1);

    run_op(0, 24'h012345, 4, 0);
    run_op(1, 24'h000100, 2, 2);
    stall_at = 1; stall_len = 20;
    run_op(1, 24'h00A5F0, 3, 0);
    stall_at = -1;
    run_op(2, 24'h123000, 0, 99);
    run_op(7, 24'h000000, 1, 0);
    run_op(5, 24'h000000, 1, 0);
    run_op(0, 24'hFFFFFF, 0, 0);

    start_op(0, 24'h012345, 4, 0);
    s0 = start_cnt; t = 0;
    while (start_cnt < s0 + 2 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("reach_addr_phase", 32'(t < 500), 1);
    @(posedge clk); #2 rst = 1'b1;
    #1 check("rst_async_cs", 32'(cs_n), 1);
    exp_tx.delete(); rx_q.delete(); exp_rd.delete(); exp_err.delete(); wr_q.delete();
    repeat (3) @(negedge clk);
    check("rst_mid_done", 32'(done), 0);
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("ready_after_midrst", 32'(req_ready), 1);
    run_op(0, 24'h0BEEF0, 3, 0);

    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 7);
      len = $urandom_range(0, 15) == 0 ? 0 : $urandom_range(1, 6);
      run_op(op, 24'($urandom), len, $urandom_range(0, 4));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
